axi_lite_rw_checker: RTL and testbench

AXI_LITE_RW_CHECKER -- requirements
Module: axi_lite_rw_checker

---
 rtl/axi_lite_rw_checker.sv | 226 ++++++++++++++++++++++
 tb/tb_axi_lite_rw_checker.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_rw_checker.sv
// ---------------------------------------------------------------------------
// axi_lite_rw_checker
//
// Purpose: AXI4-Lite master that, on a start pulse, waits GAP_CYCLES idle
// cycles, writes NUM_WORDS words (address BASE_ADDR+4*i, data DATA_SEED+i),
// waits GAP_CYCLES again, reads every word back and compares it with the
// value written. Slave error responses and read-data mismatches are counted
// without aborting the run.
//
// Ports:
//   clk, reset              clock (rising edge), async active-high reset
//   start                   single-cycle run request (IDLE/DONE only)
//   aw*/w*/b*               AXI4-Lite write address / data / response
//   ar*/r*                  AXI4-Lite read address / data
//   busy, done              run status (busy outside IDLE/DONE, done in DONE)
//   error, err_count        sticky fault flag, saturating fault count
//   dbg_state               current FSM state for observation
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high. Every valid output here is a register, so it never depends
// combinationally on a ready input; once raised it is held with a stable
// payload until its own ready is sampled high. The ready outputs (bready,
// rready) are decoded from the state register only.
// ---------------------------------------------------------------------------
module axi_lite_rw_checker #(
  parameter logic [31:0] BASE_ADDR  = 32'h10,
  parameter int          NUM_WORDS  = 4,
  parameter int          GAP_CYCLES = 8,
  parameter logic [31:0] DATA_SEED  = 32'h100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  err_count,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WGAP  = 3'd1;
  localparam logic [2:0] S_WADDR = 3'd2;
  localparam logic [2:0] S_WRESP = 3'd3;
  localparam logic [2:0] S_RGAP  = 3'd4;
  localparam logic [2:0] S_RADDR = 3'd5;
  localparam logic [2:0] S_RDATA = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  localparam logic [8:0]  LAST_IDX = 9'(NUM_WORDS - 1);
  localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES);

  logic [2:0]  r_state;
  logic [15:0] r_gap;
  logic [8:0]  r_idx;
  logic        r_awvalid;
  logic        r_wvalid;
  logic        r_arvalid;
  logic [31:0] r_awaddr;
  logic [31:0] r_wdata;
  logic [31:0] r_araddr;
  logic        r_error;
  logic [7:0]  r_err_count;

  logic [8:0]  w_next_idx;
  logic [31:0] w_cur_addr;
  logic [31:0] w_next_addr;
  logic [31:0] w_cur_data;
  logic [31:0] w_next_data;
  logic        w_last;
  logic        w_aw_ok;
  logic        w_w_ok;
  logic        w_run_start;
  logic        w_bfault;
  logic        w_rfault;

  assign w_next_idx  = r_idx + 9'd1;
  assign w_cur_addr  = BASE_ADDR + {21'd0, r_idx, 2'b00};
  assign w_next_addr = BASE_ADDR + {21'd0, w_next_idx, 2'b00};
  assign w_cur_data  = DATA_SEED + {23'd0, r_idx};
  assign w_next_data = DATA_SEED + {23'd0, w_next_idx};
  assign w_last      = (r_idx == LAST_IDX);

  // A channel is finished when its valid already dropped or it handshakes now.
  assign w_aw_ok = !r_awvalid || awready;
  assign w_w_ok  = !r_wvalid  || wready;

  assign w_run_start = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;

  // Responses are only looked at while the matching ready is high.
  assign w_bfault = (r_state == S_WRESP) && bvalid && (bresp != 2'b00);
  // A bad rresp and bad rdata on the same beat form one fault.
  assign w_rfault = (r_state == S_RDATA) && rvalid &&
                    ((rresp != 2'b00) || (rdata != w_cur_data));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_gap     <= '0;
      r_idx     <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_arvalid <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_araddr  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_WGAP;
            r_gap   <= GAP_LOAD;
            r_idx   <= '0;
          end
        end
        S_WGAP: begin
          if (r_gap == 16'd1) begin
            r_state   <= S_WADDR;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_awaddr  <= w_cur_addr;
            r_wdata   <= w_cur_data;
          end else begin
            r_gap <= r_gap - 16'd1;
          end
        end
        S_WADDR: begin
          if (awready) r_awvalid <= 1'b0;
          if (wready)  r_wvalid  <= 1'b0;
          if (w_aw_ok && w_w_ok) r_state <= S_WRESP;
        end
        S_WRESP: begin
          if (bvalid) begin
            if (!w_last) begin
              r_idx     <= w_next_idx;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_awaddr  <= w_next_addr;
              r_wdata   <= w_next_data;
              r_state   <= S_WADDR;
            end else begin
              r_idx   <= '0;
              r_gap   <= GAP_LOAD;
              r_state <= S_RGAP;
            end
          end
        end
        S_RGAP: begin
          if (r_gap == 16'd1) begin
            r_state   <= S_RADDR;
            r_arvalid <= 1'b1;
            r_araddr  <= w_cur_addr;
          end else begin
            r_gap <= r_gap - 16'd1;
          end
        end
        S_RADDR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_state   <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (rvalid) begin
            if (!w_last) begin
              r_idx     <= w_next_idx;
              r_arvalid <= 1'b1;
              r_araddr  <= w_next_addr;
              r_state   <= S_RADDR;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Fault bookkeeping: cleared when a run starts, sticky flag, saturating count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_error     <= 1'b0;
      r_err_count <= '0;
    end else if (w_run_start) begin
      r_error     <= 1'b0;
      r_err_count <= '0;
    end else if (w_bfault || w_rfault) begin
      r_error <= 1'b1;
      if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
    end
  end

  assign awaddr    = r_awaddr;
  assign awvalid   = r_awvalid;
  assign wdata     = r_wdata;
  assign wstrb     = 4'hF;
  assign wvalid    = r_wvalid;
  assign bready    = (r_state == S_WRESP);
  assign araddr    = r_araddr;
  assign arvalid   = r_arvalid;
  assign rready    = (r_state == S_RDATA);
  assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done      = (r_state == S_DONE);
  assign error     = r_error;
  assign err_count = r_err_count;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_axi_lite_rw_checker.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_rw_checker
//
// u_dut  : default parameters, driven by a small behavioural AXI-Lite slave
//          with configurable ready/response delays and fault injection.
// u_dut1 : NUM_WORDS=1, GAP_CYCLES=1, with every slave input tied to an
//          always-ready / always-valid value, stepped cycle by cycle.
// ---------------------------------------------------------------------------
module tb_axi_lite_rw_checker;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start;
  logic start1;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- DUT 0 signals ----------------
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        busy, done, error;
  logic [7:0]  err_count;
  logic [2:0]  dbg_state;

  axi_lite_rw_checker u_dut (
    .clk(clk), .reset(reset), .start(start),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .busy(busy), .done(done), .error(error), .err_count(err_count),
    .dbg_state(dbg_state)
  );

  // ---------------- DUT 1 signals ----------------
  logic [31:0] a1_awaddr, a1_wdata, a1_araddr;
  logic        a1_awvalid, a1_wvalid, a1_bready, a1_arvalid, a1_rready;
  logic [3:0]  a1_wstrb;
  logic        a1_busy, a1_done, a1_error;
  logic [7:0]  a1_err_count;
  logic [2:0]  a1_state;

  axi_lite_rw_checker #(.NUM_WORDS(1), .GAP_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .awaddr(a1_awaddr), .awvalid(a1_awvalid), .awready(1'b1),
    .wdata(a1_wdata), .wstrb(a1_wstrb), .wvalid(a1_wvalid), .wready(1'b1),
    .bresp(2'b00), .bvalid(1'b1), .bready(a1_bready),
    .araddr(a1_araddr), .arvalid(a1_arvalid), .arready(1'b1),
    .rdata(32'h100), .rresp(2'b00), .rvalid(1'b1), .rready(a1_rready),
    .busy(a1_busy), .done(a1_done), .error(a1_error), .err_count(a1_err_count),
    .dbg_state(a1_state)
  );

  // ---------------- comparison ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- slave model / scoreboard state ----------------
  int aw_delay = 0;
  int w_delay  = 0;
  int r_delay  = 0;
  int berr_word = -1;
  int rbad_word = -1;

  logic [31:0] mem [0:15];
  int          wr_cnt [0:15];
  int          rd_cnt;
  logic [31:0] exp_q [$];

  initial begin
    int aw_cnt, w_cnt, r_cnt, b_word, r_word, idx;
    logic aw_have, w_have, b_pending, r_pending;
    logic [31:0] aw_q, w_q, aw_first, off;
    aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_word = 0; r_word = 0;
    aw_have = 0; w_have = 0; b_pending = 0; r_pending = 0;
    aw_q = 0; w_q = 0; aw_first = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        aw_cnt = 0; w_cnt = 0; r_cnt = 0;
        aw_have = 0; w_have = 0; b_pending = 0; r_pending = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
      end else begin
        // write response: offered only while the master shows bready
        if (bvalid) bvalid = 0;
        else if (b_pending && bready) begin
          bvalid = 1;
          bresp = (b_word == berr_word) ? 2'b10 : 2'b00;
          b_pending = 0;
        end
        // write address: payload must stay put while waiting for awready
        if (awready) awready = 0;
        else if (awvalid) begin
          if (aw_cnt > 0) chk("aw_stable", awaddr, aw_first);
          else aw_first = awaddr;
          if (aw_cnt >= aw_delay) begin
            awready = 1; aw_q = awaddr; aw_have = 1; aw_cnt = 0;
          end else aw_cnt++;
        end
        // write data: once accepted, wvalid must not linger
        if (w_have && !wready) chk("w_dropped", {31'd0, wvalid}, 32'd0);
        if (wready) wready = 0;
        else if (wvalid && !w_have) begin
          chk("wstrb", {28'd0, wstrb}, 32'hF);
          if (w_cnt >= w_delay) begin
            wready = 1; w_q = wdata; w_have = 1; w_cnt = 0;
          end else w_cnt++;
        end
        if (aw_have && w_have) begin
          off = (aw_q - 32'h10) >> 2;
          idx = int'(off);
          if (idx >= 0 && idx < 16) begin
            mem[idx] = w_q;
            wr_cnt[idx]++;
          end
          b_word = idx; b_pending = 1; aw_have = 0; w_have = 0;
        end
        // read address
        if (arready) arready = 0;
        else if (arvalid) begin
          arready = 1;
          off = (araddr - 32'h10) >> 2;
          r_word = int'(off);
          r_pending = 1;
          rd_cnt++;
        end
        // read data, with optional latency and corruption
        if (rvalid) rvalid = 0;
        else if (r_pending && rready) begin
          if (r_cnt >= r_delay) begin
            rvalid = 1;
            rdata = (r_word >= 0 && r_word < 16) ? mem[r_word] : 32'hDEAD_BEEF;
            if (r_word == rbad_word) rdata = rdata ^ 32'h0000_00FF;
            rresp = 2'b00; r_pending = 0; r_cnt = 0;
          end else r_cnt++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_sb();
    for (int i = 0; i < 16; i++) begin
      mem[i] = 32'h0;
      wr_cnt[i] = 0;
    end
    rd_cnt = 0;
  endtask

  // Leaves the bench at the first negedge after the start edge.
  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Runs until done, counting idle busy cycles (no valid/ready asserted).
  // poke_at >= 0 pulses start at that iteration to exercise start-while-busy.
  task automatic run_to_done(input int poke_at, output int idle, output int first_gap,
                             output bit ok);
    idle = 0; first_gap = -1; ok = 0;
    for (int n = 0; n < 3000; n++) begin
      if (done) begin ok = 1; break; end
      if (first_gap < 0 && awvalid) first_gap = idle;
      if (busy && !awvalid && !wvalid && !bready && !arvalid && !rready) idle++;
      @(negedge clk);
      start = (n + 1 == poke_at);
    end
    start = 1'b0;
  endtask

  task automatic check_run(input string tag, input int exp_err, input int exp_cnt,
                           input int idle, input int first_gap, input bit ok);
    chk({tag, "_timeout"}, {31'd0, ok}, 32'd1);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'(exp_err));
    chk({tag, "_err_count"}, {24'd0, err_count}, 32'(exp_cnt));
    chk({tag, "_idle_cycles"}, 32'(idle), 32'd16);
    chk({tag, "_first_gap"}, 32'(first_gap), 32'd8);
    chk({tag, "_reads"}, 32'(rd_cnt), 32'd4);
    exp_q = {32'h100, 32'h101, 32'h102, 32'h103};
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_mem"}, mem[i], exp_q.pop_front());
      chk({tag, "_wr_once"}, 32'(wr_cnt[i]), 32'd1);
    end
  endtask

  // ---------------- directed sequence ----------------
  localparam int NSTEP = 7;
  logic [2:0] t1_state [NSTEP] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  logic       t1_aw    [NSTEP] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic       t1_ar    [NSTEP] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic       t1_done  [NSTEP] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int idle, first_gap, waited;
    bit ok;
    reset = 1'b1; start = 1'b0; start1 = 1'b0;
    clear_sb();

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_state", {29'd0, dbg_state}, 32'd0);
    chk("rst_valids", {28'd0, awvalid, wvalid, arvalid, bready}, 32'd0);
    chk("rst_status", {29'd0, busy, done, error}, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    chk("rst_wstrb", {28'd0, wstrb}, 32'hF);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_no_start", {29'd0, dbg_state}, 32'd0);

    // single word, one-cycle gaps, tied slave
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int s = 0; s < NSTEP; s++) begin
      chk("w1_state", {29'd0, a1_state}, {29'd0, t1_state[s]});
      chk("w1_awvalid", {31'd0, a1_awvalid}, {31'd0, t1_aw[s]});
      chk("w1_arvalid", {31'd0, a1_arvalid}, {31'd0, t1_ar[s]});
      chk("w1_done", {31'd0, a1_done}, {31'd0, t1_done[s]});
      if (s == 1) begin
        chk("w1_awaddr", a1_awaddr, 32'h10);
        chk("w1_wdata", a1_wdata, 32'h100);
        chk("w1_wvalid", {31'd0, a1_wvalid}, 32'd1);
      end
      if (s == 2) chk("w1_bready", {31'd0, a1_bready}, 32'd1);
      if (s == 4) chk("w1_araddr", a1_araddr, 32'h10);
      if (s == 5) chk("w1_rready", {31'd0, a1_rready}, 32'd1);
      @(negedge clk);
    end
    chk("w1_error", {23'd0, a1_error, a1_err_count}, 32'd0);

    // zero-wait slave, clean run
    clear_sb();
    pulse_start();
    run_to_done(-1, idle, first_gap, ok);
    check_run("basic", 0, 0, idle, first_gap, ok);

    // wready three cycles ahead of awready
    clear_sb();
    aw_delay = 3;
    pulse_start();
    run_to_done(-1, idle, first_gap, ok);
    check_run("aw_late", 0, 0, idle, first_gap, ok);
    aw_delay = 0;

    // SLVERR on write 1, corrupted read data on word 2
    clear_sb();
    berr_word = 1; rbad_word = 2;
    pulse_start();
    run_to_done(-1, idle, first_gap, ok);
    check_run("faults", 1, 2, idle, first_gap, ok);
    berr_word = -1; rbad_word = -1;

    // restart from DONE clears status; start while busy is ignored
    clear_sb();
    pulse_start();
    chk("restart_done", {31'd0, done}, 32'd0);
    chk("restart_error", {31'd0, error}, 32'd0);
    chk("restart_err_count", {24'd0, err_count}, 32'd0);
    chk("restart_busy", {31'd0, busy}, 32'd1);
    run_to_done(12, idle, first_gap, ok);
    check_run("busy_start", 0, 0, idle, first_gap, ok);

    // reset while waiting for read data
    clear_sb();
    r_delay = 6;
    pulse_start();
    waited = 0;
    while (!rready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    chk("reach_rdata", {31'd0, rready}, 32'd1);
    chk("rdata_pending", {31'd0, rvalid}, 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("arst_state", {29'd0, dbg_state}, 32'd0);
    chk("arst_valids", {27'd0, awvalid, wvalid, arvalid, bready, rready}, 32'd0);
    chk("arst_status", {29'd0, busy, done, error}, 32'd0);
    chk("arst_addr", awaddr | araddr | wdata, 32'd0);
    @(negedge clk);
    chk("arst_next_state", {29'd0, dbg_state}, 32'd0);
    chk("arst_next_out", {22'd0, awvalid, wvalid, arvalid, bready, rready, busy, done, error, err_count == 8'd0, 1'b0}, 32'd2);
    @(negedge clk);
    reset = 1'b0;
    r_delay = 0;
    repeat (5) @(negedge clk);
    chk("post_rst_idle", {29'd0, dbg_state}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    clear_sb();
    pulse_start();
    run_to_done(-1, idle, first_gap, ok);
    check_run("after_rst", 0, 0, idle, first_gap, ok);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
